mem_wb_stage: RTL

MEM/WB pipeline stage of the MIPS core: registers the MEM stage results into the write-back register and selects the write-back value (ALU result or SRAM load data). It sequences every load and store through a small FSM around the SRAM controller's not-ready signal. While an access is in flight it freezes the upstream pipeline, then commits exactly one write-back per instruction.

---
 rtl/mips_pkg.sv | 14 +
 rtl/mem_wb_stage_ctrl.sv | 76 +++++++
 rtl/mem_wb_stage.sv | 86 ++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: word/register widths and the MEM/WB
// sequencing states.
package mips_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        COMMIT = 2'd2
    } mem_wb_state_t;

endpackage

// File: rtl/mem_wb_stage_ctrl.sv
// MEM/WB sequencing control: walks each load/store through IDLE -> ACCESS ->
// COMMIT around the SRAM not-ready signal, raises freeze for the upstream
// pipeline and strobes which value the write-back register captures.
// Optional freeze-cycle counter enabled by defining MEM_WB_PERF_EN.
module mem_wb_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             sram_not_ready,
    output logic             freeze,
    output logic             capture_alu,
    output logic             capture_load,
    output logic             bubble,
    output logic [CNT_W-1:0] stall_cycles
);

    mem_wb_state_t state_q;
    logic          mem_op;

    assign mem_op = mem_read | mem_write;

    // Access sequencer: one pass through ACCESS and COMMIT per memory instruction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE:    if (mem_op) state_q <= ACCESS;
                ACCESS:  if (!sram_not_ready) state_q <= COMMIT;
                COMMIT:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Freeze and capture strobes decoded from the current state; freeze is
    // gated by rst so a reset mid-access releases the pipeline immediately.
    always_comb begin
        freeze       = rst & (((state_q == IDLE) & mem_op) | (state_q == ACCESS));
        capture_alu  = (state_q == IDLE) & ~mem_op;
        capture_load = (state_q == ACCESS) & ~sram_not_ready;
        bubble       = ~(capture_alu | capture_load);
    end

`ifdef MEM_WB_PERF_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] stall_d;

    // Saturating count of frozen cycles.
    always_comb begin
        stall_d = stall_q;
        if (freeze && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    // Counter register, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: write-back register plus ALU/load select, with
// memory accesses sequenced by mem_wb_ctrl. Define MEM_WB_PERF_EN to enable
// the stall_cycles counter (tied to zero otherwise).
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W = WORD_W,
    parameter int unsigned DEST_W = REG_ADDR_W,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              wb_en_in,
    input  logic [DEST_W-1:0] dest_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] read_data_in,
    input  logic              sram_not_ready,
    output logic              freeze,
    output logic              wb_en,
    output logic [DEST_W-1:0] wb_dest,
    output logic [DATA_W-1:0] wb_value,
    output logic [CNT_W-1:0]  stall_cycles
);

    logic capture_alu;
    logic capture_load;
    logic bubble;

    logic              wb_en_q,    wb_en_d;
    logic [DEST_W-1:0] wb_dest_q,  wb_dest_d;
    logic [DATA_W-1:0] wb_value_q, wb_value_d;

    mem_wb_ctrl #(
        .CNT_W (CNT_W)
    ) u_ctrl (
        .clk            (clk),
        .rst            (rst),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .sram_not_ready (sram_not_ready),
        .freeze         (freeze),
        .capture_alu    (capture_alu),
        .capture_load   (capture_load),
        .bubble         (bubble),
        .stall_cycles   (stall_cycles)
    );

    // Write-back mux: load data on access completion, ALU result for
    // non-memory instructions, otherwise a bubble that keeps dest/value.
    always_comb begin
        wb_en_d    = wb_en_q;
        wb_dest_d  = wb_dest_q;
        wb_value_d = wb_value_q;
        if (capture_load) begin
            wb_en_d    = wb_en_in & mem_read;
            wb_dest_d  = dest_in;
            wb_value_d = read_data_in;
        end else if (capture_alu) begin
            wb_en_d    = wb_en_in;
            wb_dest_d  = dest_in;
            wb_value_d = alu_result_in;
        end else if (bubble) begin
            wb_en_d    = 1'b0;
        end
    end

    // Write-back register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_en_q    <= 1'b0;
            wb_dest_q  <= '0;
            wb_value_q <= '0;
        end else begin
            wb_en_q    <= wb_en_d;
            wb_dest_q  <= wb_dest_d;
            wb_value_q <= wb_value_d;
        end
    end

    assign wb_en    = wb_en_q;
    assign wb_dest  = wb_dest_q;
    assign wb_value = wb_value_q;

endmodule
